// File: rtl/nes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module      : nes_pad_reader
// Description : Polls one NES controller over its latch/clock/data link.
//               A one-cycle poll_i strobe (taken only while idle) starts a
//               frame: latch pulse of 2*HALF_PERIOD cycles, then eight shift
//               clock pulses of HALF_PERIOD high / HALF_PERIOD low. Bit 0 is
//               captured at the end of the latch, bits 1..7 at the end of the
//               low half of pulses 1..7; pulse 8 only completes the protocol.
//               The captured byte is presented active-high on buttons_o with
//               a one-cycle valid_o strobe.
// Ports       : clk          in   system clock, rising edge
//               reset        in   asynchronous active-high reset
//               poll_i       in   1-cycle frame start strobe (idle only)
//               nes_data_i   in   controller serial data, active-low
//               nes_latch_o  out  controller latch, active-high, registered
//               nes_clk_o    out  controller shift clock, idle low, registered
//               buttons_o    out  [0]A [1]B [2]Sel [3]Start [4]Up [5]Down
//                                 [6]Left [7]Right, active-high
//               valid_o      out  1-cycle strobe, frame complete
//               busy_o       out  high from latch through done
// Config      : NES_DEBOUNCE_EN - when defined, buttons_o only updates when a
//               frame matches the previously captured frame.
// Revision    : 1.0 - initial release
// ============================================================================
module nes_pad_reader #(
  parameter int HALF_PERIOD = 6,
  parameter int NUM_BITS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                poll_i,
  input  logic                nes_data_i,
  output logic                nes_latch_o,
  output logic                nes_clk_o,
  output logic [NUM_BITS-1:0] buttons_o,
  output logic                valid_o,
  output logic                busy_o
);

  localparam int c_cnt_w = $clog2(2*HALF_PERIOD+1);
  localparam int c_idx_w = $clog2(NUM_BITS+1);
  localparam int c_sel_w = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  // Counters are loaded with (length - 1) and the phase ends when they reach 0.
  localparam logic [c_cnt_w-1:0] c_latch_load = c_cnt_w'(2*HALF_PERIOD-1);
  localparam logic [c_cnt_w-1:0] c_half_load  = c_cnt_w'(HALF_PERIOD-1);
  localparam logic [c_idx_w-1:0] c_last_idx   = c_idx_w'(NUM_BITS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_PULSE_HI = 3'd2,
    S_PULSE_LO = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_idx_w-1:0]  r_idx;
  logic [NUM_BITS-1:0] r_shift;
`ifdef NES_DEBOUNCE_EN
  logic [NUM_BITS-1:0] r_prev;
`endif

  // All outputs are registered and are set on the edge that enters the state
  // they belong to, so they line up exactly with the state occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      nes_latch_o <= 1'b0;
      nes_clk_o   <= 1'b0;
      buttons_o   <= '0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
`ifdef NES_DEBOUNCE_EN
      r_prev      <= '0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (poll_i) begin
            r_state     <= S_LATCH;
            r_cnt       <= c_latch_load;
            r_shift     <= '0;
            nes_latch_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end

        S_LATCH: begin
          if (r_cnt == '0) begin
            // The controller presents button A while latched.
            r_shift[0]  <= ~nes_data_i;
            r_idx       <= c_idx_w'(1);
            r_cnt       <= c_half_load;
            nes_latch_o <= 1'b0;
            nes_clk_o   <= 1'b1;
            r_state     <= S_PULSE_HI;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_PULSE_HI: begin
          if (r_cnt == '0) begin
            r_cnt     <= c_half_load;
            nes_clk_o <= 1'b0;
            r_state   <= S_PULSE_LO;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_PULSE_LO: begin
          if (r_cnt == '0) begin
            // Sample late in the low half so the data has long settled after
            // the controller shifted on the preceding rising clock edge.
            if (r_idx < c_last_idx) begin
              r_shift[r_idx[c_sel_w-1:0]] <= ~nes_data_i;
            end
            if (r_idx == c_last_idx) begin
              r_state <= S_DONE;
              valid_o <= 1'b1;
`ifdef NES_DEBOUNCE_EN
              // Two consecutive identical frames are required to publish.
              if (r_shift == r_prev) begin
                buttons_o <= r_shift;
              end
              r_prev <= r_shift;
`else
              buttons_o <= r_shift;
`endif
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_cnt     <= c_half_load;
              nes_clk_o <= 1'b1;
              r_state   <= S_PULSE_HI;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_DONE: begin
          // poll_i is deliberately not looked at here.
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          nes_latch_o <= 1'b0;
          nes_clk_o   <= 1'b0;
          busy_o      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
